// File: rtl/s86_pg_pkg.sv
// rtl/s86_pg_pkg.sv - shared types and constants for the UART program loader
package s86_pg_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CH, S_ADRL, S_ADRH, S_LENL, S_LENH, S_DATA, S_SUM
  } pg_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [1:0] ERR_FRAME = 2'd0;
  localparam logic [1:0] ERR_CHAN  = 2'd1;
  localparam logic [1:0] ERR_SUM   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with 2-FF synchroniser
module uart_rx_core
  import s86_pg_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC + 1);

  rx_state_e     state_q;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RX_IDLE;
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_o      <= '0;
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      prev_q      <= sync_q[1];
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (!en_i) begin
        state_q <= RX_IDLE;
      end else begin
        case (state_q)
          RX_IDLE: if (prev_q && !sync_q[1]) begin
            state_q <= RX_START;
            cnt_q   <= CW'(HALF - 1);
          end
          RX_START: if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (sync_q[1]) begin
            state_q <= RX_IDLE;  // glitch shorter than half a bit
          end else begin
            state_q <= RX_DATA;
            cnt_q   <= CW'(BIT_CYC - 1);
            bit_q   <= '0;
          end
          RX_DATA: if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            shift_q <= {sync_q[1], shift_q[7:1]};
            cnt_q   <= CW'(BIT_CYC - 1);
            if (bit_q == 3'd7) state_q <= RX_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end
          default: if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= RX_IDLE;
            if (sync_q[1]) begin
              byte_o     <= shift_q;
              byte_vld_o <= 1'b1;
            end else begin
              frame_err_o <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - framed UART downloader writing words into NCH target memories
module uart_prog_loader
  import s86_pg_pkg::*;
#(
  parameter int CLK_HZ      = 10_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int NCH         = 2,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              rx_i,
  output logic [NCH-1:0]    pg_wen_o,
  output logic [ADDR_W-1:0] pg_adr_o,
  output logic [DATA_W-1:0] pg_dat_o,
  output logic              pg_busy_o,
  output logic              pg_done_o,
  output logic              pg_err_o,
  output logic [1:0]        err_code_o
);

  localparam int BPW = DATA_W / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_ferr;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .rx_i       (rx_i),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld),
    .frame_err_o(rx_ferr)
  );

  pg_state_e   state_q;
  logic [2:0]  ch_q;
  logic [7:0]  lo_q;
  logic [ADDR_W-1:0] adr_q;
  logic [15:0] len_q;
  logic [BW-1:0] bidx_q;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]  sum_q;
  logic [31:0] tmo_q;
  logic [15:0] hdr16;

  always_comb begin
    word_d = word_q;
    word_d[{bidx_q, 3'b000} +: 8] = rx_byte;
    hdr16 = {rx_byte, lo_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ch_q <= '0; lo_q <= '0; adr_q <= '0; len_q <= '0;
      bidx_q <= '0; word_q <= '0; sum_q <= '0; tmo_q <= '0;
      pg_wen_o <= '0; pg_adr_o <= '0; pg_dat_o <= '0;
      pg_busy_o <= 1'b0; pg_done_o <= 1'b0; pg_err_o <= 1'b0; err_code_o <= '0;
    end else begin
      pg_wen_o <= '0;
      if (!en_i) begin
        state_q   <= S_IDLE;
        pg_busy_o <= 1'b0;
        pg_done_o <= 1'b0;
        pg_err_o  <= 1'b0;
        tmo_q     <= '0;
      end else if (state_q == S_IDLE) begin
        tmo_q <= '0;
        if (rx_vld && rx_byte == HDR_BYTE) begin
          state_q   <= S_CH;
          pg_busy_o <= 1'b1;
          pg_done_o <= 1'b0;
          pg_err_o  <= 1'b0;
          sum_q     <= '0;
          bidx_q    <= '0;
        end
      end else if (rx_ferr) begin
        state_q <= S_IDLE; pg_busy_o <= 1'b0; pg_err_o <= 1'b1; err_code_o <= ERR_FRAME;
      end else if (rx_vld) begin
        // a byte landing on the expiry cycle takes priority and restarts the timer
        tmo_q <= '0;
        sum_q <= sum_q + rx_byte;
        case (state_q)
          S_CH: if (rx_byte >= 8'(NCH)) begin
            state_q <= S_IDLE; pg_busy_o <= 1'b0; pg_err_o <= 1'b1; err_code_o <= ERR_CHAN;
          end else begin
            ch_q <= rx_byte[2:0]; state_q <= S_ADRL;
          end
          S_ADRL: begin lo_q <= rx_byte; state_q <= S_ADRH; end
          S_ADRH: begin adr_q <= hdr16[ADDR_W-1:0]; state_q <= S_LENL; end
          S_LENL: begin lo_q <= rx_byte; state_q <= S_LENH; end
          S_LENH: begin
            len_q   <= hdr16;
            bidx_q  <= '0;
            state_q <= (hdr16 == 16'd0) ? S_SUM : S_DATA;
          end
          S_DATA: begin
            word_q <= word_d;
            if (bidx_q == BW'(BPW - 1)) begin
              bidx_q   <= '0;
              pg_wen_o <= NCH'(1) << ch_q;
              pg_adr_o <= adr_q;
              pg_dat_o <= word_d;
              adr_q    <= adr_q + ADDR_W'(1);
              len_q    <= len_q - 16'd1;
              if (len_q == 16'd1) state_q <= S_SUM;
            end else begin
              bidx_q <= bidx_q + BW'(1);
            end
          end
          default: begin
            state_q   <= S_IDLE;
            pg_busy_o <= 1'b0;
            if (rx_byte == sum_q) begin
              pg_done_o <= 1'b1;
            end else begin
              pg_err_o <= 1'b1; err_code_o <= ERR_SUM;
            end
          end
        endcase
      end else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
        state_q <= S_IDLE; pg_busy_o <= 1'b0; pg_err_o <= 1'b1; err_code_o <= ERR_TMO;
      end else begin
        tmo_q <= tmo_q + 32'd1;
      end
    end
  end

endmodule
